// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared fetch-unit state encoding, Sysbus request tag and
//               line-geometry helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE    = 2'd0;
    localparam fetch_state_t ST_REQ     = 2'd1;
    localparam fetch_state_t ST_RESP    = 2'd2;
    localparam fetch_state_t ST_DISCARD = 2'd3;

    localparam int SYSBUS_READ   = 1;
    localparam int SYSBUS_MEMORY = 1;
    localparam int REQ_TAG       = (SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8);

    localparam int DEF_BUS_DATA_WIDTH = 64;
    localparam int DEF_INSN_WIDTH     = 32;
    localparam int DEF_BEATS          = 8;

    localparam int IPB        = DEF_BUS_DATA_WIDTH / DEF_INSN_WIDTH;
    localparam int LINE_INSNS = DEF_BEATS * IPB;
    localparam int LINE_BYTES = DEF_BEATS * DEF_BUS_DATA_WIDTH / 8;

    function automatic int calc_ipb(input int bus_w, input int insn_w);
        return bus_w / insn_w;
    endfunction

    function automatic int calc_line_bytes(input int bus_w, input int beats);
        return beats * bus_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Instruction buffer of {insn, pc}; up to LANES packed writes
//               per cycle, one read, synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH      = 16,
    parameter int LANES      = 2,
    parameter int INSN_WIDTH = 32,
    parameter int CW         = $clog2(DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic [LANES-1:0]                     wr_en,
    input  logic [LANES-1:0][INSN_WIDTH-1:0]     wr_insn,
    input  logic [LANES-1:0][63:0]               wr_pc,
    input  logic                                 rd_en,
    output logic [INSN_WIDTH-1:0]                rd_insn,
    output logic [63:0]                          rd_pc,
    output logic                                 empty,
    output logic [CW-1:0]                        count,
    output logic [CW-1:0]                        free
);

    localparam int AW = $clog2(DEPTH);

    logic [INSN_WIDTH-1:0] r_mem_insn [DEPTH];
    logic [63:0]           r_mem_pc   [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic [AW-1:0]         w_slot [LANES];
    logic [CW-1:0]         w_nwr;
    logic                  w_pop;

    // Enabled lanes are packed contiguously from the write pointer.
    always_comb begin
        w_nwr = '0;
        for (int l = 0; l < LANES; l++) begin
            w_slot[l] = r_wptr + w_nwr[AW-1:0];
            w_nwr     = w_nwr + CW'(wr_en[l]);
        end
    end

    assign w_pop = rd_en && (r_count != '0);

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_en[l]) begin
                r_mem_insn[w_slot[l]] <= wr_insn[l];
                r_mem_pc[w_slot[l]]   <= wr_pc[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + w_nwr[AW-1:0];
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + w_nwr - CW'(w_pop);
        end
    end

    assign rd_insn = r_mem_insn[r_rptr];
    assign rd_pc   = r_mem_pc[r_rptr];
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign free    = CW'(DEPTH) - r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_line_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_line_unit
// Description : Line-burst instruction fetch front end: Sysbus reads, beat
//               unpacking, buffering and valid/ready hand-off to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_line_unit
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int INSN_WIDTH     = 32,
    parameter int BEATS          = 8,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      insn_valid,
    input  logic                      insn_ready,
    output logic [INSN_WIDTH-1:0]     insn,
    output logic [63:0]               insn_pc,
    output logic                      halt
);

    localparam int N_IPB        = calc_ipb(BUS_DATA_WIDTH, INSN_WIDTH);
    localparam int N_LINE_INSNS = BEATS * N_IPB;
    localparam int N_LINE_BYTES = calc_line_bytes(BUS_DATA_WIDTH, BEATS);
    localparam int BEAT_BYTES   = BUS_DATA_WIDTH / 8;
    localparam int INSN_BYTES   = INSN_WIDTH / 8;
    localparam int CW           = $clog2(FIFO_DEPTH) + 1;
    localparam int BW           = $clog2(BEATS + 1);
    localparam logic [63:0] LINE_MASK = ~(64'(N_LINE_BYTES) - 64'd1);

    fetch_state_t              r_state;
    logic [63:0]               r_fetch_pc;
    logic [63:0]               r_skip_pc;
    logic [BW-1:0]             r_beat;
    logic                      r_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] r_req;
    logic                      r_respack;
    logic                      r_halt;

    logic                                w_beat_acc;
    logic                                w_last_beat;
    logic                                w_write_beat;
    logic [63:0]                         w_beat_pc;
    logic [N_IPB-1:0]                    w_wr_en;
    logic [N_IPB-1:0][INSN_WIDTH-1:0]    w_wr_insn;
    logic [N_IPB-1:0][63:0]              w_wr_pc;
    logic                                w_pop;
    logic                                w_fifo_empty;
    logic [CW-1:0]                       w_count;
    logic [CW-1:0]                       w_free;
    logic [INSN_WIDTH-1:0]               w_head_insn;
    logic [63:0]                         w_head_pc;
    logic                                w_can_fetch;
    logic                                w_unused_sig;

    // Beats are only counted once the request handshake has completed.
    assign w_beat_acc   = bus_respcyc &&
                          ((r_state == ST_RESP) || ((r_state == ST_DISCARD) && !r_reqcyc));
    assign w_last_beat  = w_beat_acc && (r_beat == BW'(BEATS - 1));
    assign w_write_beat = bus_respcyc && (r_state == ST_RESP) && !redirect_valid;
    assign w_beat_pc    = r_fetch_pc + 64'(r_beat) * 64'(BEAT_BYTES);

    generate
        for (genvar k = 0; k < N_IPB; k++) begin : g_lane
            assign w_wr_insn[k] = bus_resp[k*INSN_WIDTH +: INSN_WIDTH];
            assign w_wr_pc[k]   = w_beat_pc + 64'(k * INSN_BYTES);
            assign w_wr_en[k]   = w_write_beat && (w_wr_pc[k] >= r_skip_pc);
        end
    endgenerate

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .LANES      (N_IPB),
        .INSN_WIDTH (INSN_WIDTH),
        .CW         (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect_valid),
        .wr_en   (w_wr_en),
        .wr_insn (w_wr_insn),
        .wr_pc   (w_wr_pc),
        .rd_en   (w_pop),
        .rd_insn (w_head_insn),
        .rd_pc   (w_head_pc),
        .empty   (w_fifo_empty),
        .count   (w_count),
        .free    (w_free)
    );

    assign insn_valid  = !w_fifo_empty && !redirect_valid && !r_halt;
    assign w_pop       = insn_valid && insn_ready;
    assign w_can_fetch = !r_halt && (w_free >= CW'(N_LINE_INSNS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= entry & LINE_MASK;
            r_skip_pc  <= entry;
            r_beat     <= '0;
            r_reqcyc   <= 1'b0;
            r_req      <= '0;
            r_respack  <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_respack <= w_beat_acc;

            if (redirect_valid) begin
                r_halt <= 1'b0;
            end else if (w_pop && (w_head_insn == '0)) begin
                r_halt <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!redirect_valid && w_can_fetch) begin
                        r_state  <= ST_REQ;
                        r_reqcyc <= 1'b1;
                        r_req    <= BUS_DATA_WIDTH'(r_fetch_pc);
                        r_beat   <= '0;
                    end
                end
                ST_REQ: begin
                    if (bus_reqack) begin
                        r_reqcyc <= 1'b0;
                        r_state  <= redirect_valid ? ST_DISCARD : ST_RESP;
                    end else if (redirect_valid) begin
                        r_state <= ST_DISCARD;
                    end
                end
                ST_RESP: begin
                    // Advancing skip_pc with the line keeps the filter correct across a 2^64 wrap.
                    if (w_last_beat) begin
                        r_state    <= ST_IDLE;
                        r_beat     <= '0;
                        r_fetch_pc <= r_fetch_pc + 64'(N_LINE_BYTES);
                        r_skip_pc  <= r_fetch_pc + 64'(N_LINE_BYTES);
                    end else begin
                        if (w_beat_acc) begin
                            r_beat <= r_beat + BW'(1);
                        end
                        if (redirect_valid) begin
                            r_state <= ST_DISCARD;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (r_reqcyc && bus_reqack) begin
                        r_reqcyc <= 1'b0;
                    end
                    if (w_last_beat) begin
                        r_state <= ST_IDLE;
                        r_beat  <= '0;
                    end else if (w_beat_acc) begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A redirect overrides any line advance made in the same cycle.
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & LINE_MASK;
                r_skip_pc  <= redirect_pc;
            end
        end
    end

    assign bus_reqcyc   = r_reqcyc;
    assign bus_req      = r_req;
    assign bus_reqtag   = BUS_TAG_WIDTH'(REQ_TAG);
    assign bus_respack  = r_respack;
    assign insn         = w_head_insn;
    assign insn_pc      = w_head_pc;
    assign halt         = r_halt;
    assign w_unused_sig = ^{bus_resptag, w_count};

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_line_unit
// Description : Randomized bench: Sysbus memory responder plus a program-order
//               reference stream for fetch_line_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_line_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [63:0] insn_pc;
    logic        halt;

    always #5 clk = ~clk;

    fetch_line_unit dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .bus_respack    (bus_respack),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .halt           (halt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: program-order stream plus expected line address.
    logic [63:0] exp_pc;
    logic [63:0] exp_fetch;
    logic [63:0] req_addr;
    int          bstate;
    int          ack_delay;
    int          beat_idx;
    bit          discard;
    bit          m_halt;
    int          halt_cyc;
    int          delivered;
    int          nreq;
    bit          exp_ack;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] h;
        h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
        h = h ^ (h >> 15);
        if (h[6:0] == 7'd0 && a >= 64'h1100) return 32'd0;
        if (h == 32'd0) h = 32'h1;
        return h;
    endfunction

    task automatic do_reset(input logic [63:0] ent);
        @(negedge clk);
        reset          = 1'b1;
        entry          = ent;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b0;
        bus_resp       = 64'd0;
        bus_resptag    = 13'd0;
        insn_ready     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_reqcyc",  64'(bus_reqcyc),  64'd0);
        check("rst_req",     bus_req,          64'd0);
        check("rst_respack", 64'(bus_respack), 64'd0);
        check("rst_halt",    64'(halt),        64'd0);
        check("rst_valid",   64'(insn_valid),  64'd0);
        @(negedge clk);
        reset     = 1'b0;
        exp_pc    = ent;
        exp_fetch = ent & ~64'h3F;
        bstate    = 0;
        discard   = 1'b0;
        m_halt    = 1'b0;
        halt_cyc  = 0;
        nreq      = 0;
        exp_ack   = 1'b0;
    endtask

    task automatic run(input int n, input int ready_pct, input bit allow_redir);
        for (int c = 0; c < n; c++) begin
            bit          drove_beat;
            bit          last_beat;
            bit          redir;
            bit          popped;
            logic [63:0] target;
            logic [63:0] base;
            @(negedge clk);
            check("respack", 64'(bus_respack), 64'(exp_ack));
            if (m_halt) halt_cyc++;
            check("halt", 64'(halt), 64'(m_halt));

            bus_reqack  = 1'b0;
            bus_respcyc = 1'b0;
            bus_resp    = {$urandom, $urandom};
            bus_resptag = 13'($urandom);
            drove_beat  = 1'b0;
            last_beat   = 1'b0;
            if (bstate == 2) begin
                if ($urandom_range(0, 3) != 0) begin
                    base        = req_addr + 64'(beat_idx * 8);
                    bus_respcyc = 1'b1;
                    bus_resp    = {mem_word(base + 64'd4), mem_word(base)};
                    drove_beat  = 1'b1;
                    beat_idx++;
                    if (beat_idx == 8) begin
                        last_beat = 1'b1;
                        bstate    = 0;
                    end
                end
            end else begin
                if (bstate == 0 && bus_reqcyc) begin
                    check("req_addr", bus_req, exp_fetch);
                    check("req_tag", 64'(bus_reqtag), 64'h1100);
                    check("no_req_halted", 64'(halt_cyc >= 2), 64'd0);
                    nreq++;
                    req_addr  = bus_req;
                    discard   = 1'b0;
                    ack_delay = $urandom_range(0, 5);
                    bstate    = 1;
                end
                if (bstate == 1) begin
                    check("req_hold_cyc",  64'(bus_reqcyc), 64'd1);
                    check("req_hold_addr", bus_req, req_addr);
                    if (ack_delay == 0) begin
                        bus_reqack = 1'b1;
                        bstate     = 2;
                        beat_idx   = 0;
                    end else begin
                        ack_delay--;
                    end
                end else if (bstate == 0 && $urandom_range(0, 9) == 0) begin
                    bus_respcyc = 1'b1;
                end
            end

            redir  = 1'b0;
            target = 64'd0;
            if (allow_redir) begin
                if (m_halt && halt_cyc > 4) redir = 1'b1;
                else if ($urandom_range(0, 99) < 2) redir = 1'b1;
            end
            if (redir) begin
                if ($urandom_range(0, 9) == 0) target = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 63) * 4);
                else target = 64'h2000 + 64'($urandom_range(0, 1023) * 4);
            end
            redirect_valid = redir;
            redirect_pc    = redir ? target : 64'($urandom);
            insn_ready     = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (redir || m_halt) check("valid_gated", 64'(insn_valid), 64'd0);
            popped = 1'b0;
            if (insn_valid && insn_ready) begin
                check("insn_pc", insn_pc, exp_pc);
                check("insn", 64'(insn), 64'(mem_word(exp_pc)));
                popped = 1'b1;
            end

            @(posedge clk);
            exp_ack = drove_beat;
            if (popped) begin
                delivered++;
                if (mem_word(exp_pc) == 32'd0) begin
                    m_halt   = 1'b1;
                    halt_cyc = 0;
                end
                exp_pc = exp_pc + 64'd4;
            end
            if (last_beat && !discard) exp_fetch = exp_fetch + 64'd64;
            if (redir) begin
                exp_pc    = target;
                exp_fetch = target & ~64'h3F;
                m_halt    = 1'b0;
                halt_cyc  = 0;
                if (bstate != 0) discard = 1'b1;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        entry          = 64'h1000;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b0;
        bus_resp       = 64'd0;
        bus_resptag    = 13'd0;
        insn_ready     = 1'b0;
        delivered      = 0;

        do_reset(64'h1000);
        run(1500, 80, 1'b1);

        // Decoder stalled: a single line fills the buffer and fetch stops.
        do_reset(64'h1008);
        run(80, 0, 1'b0);
        check("one_line_nreq", 64'(nreq), 64'd1);
        check("stall_reqcyc", 64'(bus_reqcyc), 64'd0);
        run(1500, 60, 1'b1);

        check("progress", 64'(delivered > 200), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
